// File: rtl/udma_cfg_apb_master.sv
// Purpose : APB slave to uDMA config-bus initiator; decodes PADDR into a target index and register address.
// Latency : 3 cycles per transfer to an always-ready target (setup, ACCESS, DONE with PREADY); 2 cycles for a bad index.
// Backpressure: the APB transfer stalls in ACCESS (PREADY low) until the selected target raises cfg_ready_i.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE   APB request; PADDR[11:7] = target index, PADDR[6:2] = register address
//   PRDATA/PREADY/PSLVERR              APB response, non-zero only in the DONE cycle
//   cfg_data_o/cfg_addr_o/cfg_rwn_o    request fields shared by all targets (rwn: 1 = read)
//   cfg_valid_o                        one-hot request strobe, bit k selects target k
//   cfg_data_i/cfg_ready_i             per-target read data (target k at [32k+31:32k]) and ready
//
// Build option: define UDMA_CFG_TIMEOUT_EN to abort an ACCESS phase with PSLVERR after
// TIMEOUT_CYCLES cycles without a ready from the selected target.
module udma_cfg_apb_master #(
  parameter int N_PERIPHS      = 6,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_rwn_o,
  output logic [N_PERIPHS-1:0]      cfg_valid_o,
  input  logic [32*N_PERIPHS-1:0]   cfg_data_i,
  input  logic [N_PERIPHS-1:0]      cfg_ready_i
);

  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;

  // Decode of the address presented during the setup phase.
  logic [IDX_W-1:0]     p_idx;
  logic                 p_idx_ok;
  logic [N_PERIPHS-1:0] p_onehot;

  // Byte-offset bits and any address bits above the index field carry no meaning here.
  logic paddr_unused;
  assign paddr_unused = ^PADDR;

  assign p_idx    = PADDR[11:7];
  assign p_idx_ok = (int'(p_idx) < N_PERIPHS);

  always_comb begin
    p_onehot = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      p_onehot[k] = (p_idx == IDX_W'(k));
    end
  end

  // Ready/data of the currently selected target; other targets' ready bits never reach the FSM.
  logic        sel_ready;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = cfg_ready_i[k];
        sel_rdata = cfg_data_i[32*k +: 32];
      end
    end
  end

`ifdef UDMA_CFG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             to_hit;

  // The counter holds the number of ACCESS cycles already spent without a ready,
  // so the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // PRDATA and PSLVERR double as the captured read-data and error registers: they are
  // loaded on the way into DONE and cleared on the way out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      cfg_rwn_o   <= 1'b0;
      cfg_valid_o <= '0;
      PRDATA      <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
`ifdef UDMA_CFG_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            idx_q      <= p_idx;
            cfg_addr_o <= PADDR[6:2];
            cfg_rwn_o  <= ~PWRITE;
            cfg_data_o <= PWDATA;
            if (p_idx_ok) begin
              cfg_valid_o <= p_onehot;
              state_q     <= ST_ACCESS;
`ifdef UDMA_CFG_TIMEOUT_EN
              to_cnt_q    <= '0;
`endif
            end else begin
              // Unmapped target: answer with an error without touching the cfg bus.
              PRDATA  <= '0;
              PSLVERR <= 1'b1;
              PREADY  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          if (sel_ready) begin
            cfg_valid_o <= '0;
            PRDATA      <= cfg_rwn_o ? sel_rdata : 32'h0;
            PSLVERR     <= 1'b0;
            PREADY      <= 1'b1;
            state_q     <= ST_DONE;
          end
`ifdef UDMA_CFG_TIMEOUT_EN
          else if (to_hit) begin
            cfg_valid_o <= '0;
            PRDATA      <= '0;
            PSLVERR     <= 1'b1;
            PREADY      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
`endif
        end

        ST_DONE: begin
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          PREADY  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_cfg_apb_master.sv
// Purpose : self-checking bench for udma_cfg_apb_master (directed table, hand sequences, random vs. model).
// Latency : drives one APB transfer at a time; outputs sampled on the falling edge.
// Backpressure: bench-side targets raise cfg_ready after a programmable number of valid cycles.
module tb_udma_cfg_apb_master;

  localparam int N  = 6;
  localparam int TO = 8;
`ifdef UDMA_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [11:0]       PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic              PWRITE = 1'b0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [31:0]       cfg_data_o;
  logic [4:0]        cfg_addr_o;
  logic              cfg_rwn_o;
  logic [N-1:0]      cfg_valid_o;
  logic [32*N-1:0]   cfg_data_i = '0;
  logic [N-1:0]      cfg_ready_i = '0;

  always #5 clk_i = ~clk_i;

  udma_cfg_apb_master #(
    .N_PERIPHS(N),
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR),
    .cfg_data_o(cfg_data_o),
    .cfg_addr_o(cfg_addr_o),
    .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o),
    .cfg_data_i(cfg_data_i),
    .cfg_ready_i(cfg_ready_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Bench-side target register files, and the reference model's own copy.
  logic [31:0] tgt_mem   [N][32];
  logic [31:0] model_mem [N][32];
  int          tgt_delay [N];
  int          vcnt      [N];

  // Targets: ready after tgt_delay valid cycles; unselected targets toggle ready/data randomly.
  always @(negedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (cfg_valid_o[k]) begin
        vcnt[k]++;
        cfg_ready_i[k] = (vcnt[k] > tgt_delay[k]);
        cfg_data_i[32*k +: 32] = tgt_mem[k][cfg_addr_o];
        if (cfg_ready_i[k] && !cfg_rwn_o) tgt_mem[k][cfg_addr_o] = cfg_data_o;
      end else begin
        vcnt[k] = 0;
        cfg_ready_i[k] = 1'($urandom_range(0, 1));
        cfg_data_i[32*k +: 32] = $urandom;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: mapped targets answer after their delay, unmapped indices error at once,
  // slow targets (timeout build) error after TO cycles; writes land in the register file.
  task automatic model(input logic [11:0] a, input logic [31:0] wd, input logic wr, input int dly,
                       output logic [31:0] rd, output logic err, output int cyc, output int vcyc);
    int idx;
    int ra;
    idx = int'(a[11:7]);
    ra  = int'(a[6:2]);
    rd  = '0;
    if (idx >= N) begin
      err = 1'b1; cyc = 2; vcyc = 0;
    end else if (TO_EN && dly >= TO) begin
      err = 1'b1; cyc = TO + 2; vcyc = TO;
    end else begin
      err = 1'b0; cyc = dly + 3; vcyc = dly + 1;
      if (wr) model_mem[idx][ra] = wd;
      else    rd = model_mem[idx][ra];
    end
  endtask

  // One APB transfer starting at the next falling edge; setup phase counts as cycle 1.
  // bad counts cycles that break the cfg-bus or APB-response rules.
  task automatic xfer(input logic [11:0] a, input logic [31:0] wd, input logic wr,
                      output logic [31:0] rd, output logic err, output int cyc,
                      output int vcyc, output int bad);
    logic [N-1:0] oh;
    int           idx;
    bit           done;
    idx  = int'(a[11:7]);
    oh   = '0;
    if (idx < N) oh[idx] = 1'b1;
    rd   = '0; err = 1'b0; vcyc = 0; bad = 0; done = 1'b0;
    @(negedge clk_i);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      PENABLE = 1'b1;
      PWDATA  = $urandom;
      if (PREADY) begin
        rd = PRDATA; err = PSLVERR; done = 1'b1;
        if (cfg_valid_o != '0) bad++;
      end else begin
        if (PSLVERR || PRDATA != 32'h0) bad++;
        if (oh != '0 && cfg_valid_o == oh) begin
          vcyc++;
          if (cfg_addr_o != a[6:2] || cfg_data_o != wd || cfg_rwn_o != !wr) bad++;
        end else if (cfg_valid_o != '0) begin
          bad++;
        end
      end
    end
  endtask

  task automatic run_chk(input string nm, input logic [11:0] a, input logic [31:0] wd, input logic wr,
                         input logic [31:0] e_rd, input logic e_err, input int e_cyc, input int e_vcyc);
    logic [31:0] rd;
    logic        err;
    int          cyc, vcyc, bad;
    xfer(a, wd, wr, rd, err, cyc, vcyc, bad);
    chk({nm, "_prdata"},  rd, e_rd);
    chk({nm, "_pslverr"}, 32'(err), 32'(e_err));
    chk({nm, "_cycles"},  32'(cyc), 32'(e_cyc));
    chk({nm, "_vcycles"}, 32'(vcyc), 32'(e_vcyc));
    chk({nm, "_busrule"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          delay;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
    int          exp_vcyc;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] m_rd;
    logic        m_err;
    int          m_cyc, m_vcyc, idx, dly;
    logic [11:0] a;
    logic [31:0] wd;
    logic        wr;

    vt[0] = '{12'h004, 32'h04030201, 1'b1, 0, 32'h00000000, 1'b0, 3, 1};
    vt[1] = '{12'h088, 32'h00000000, 1'b0, 4, 32'hCAFEF00D, 1'b0, 7, 5};
    vt[2] = '{12'h380, 32'h12345678, 1'b0, 0, 32'h00000000, 1'b1, 2, 0};
    vt[3] = '{12'h008, 32'h11112222, 1'b1, 0, 32'h00000000, 1'b0, 3, 1};
    vt[4] = '{12'h184, 32'h33334444, 1'b1, 0, 32'h00000000, 1'b0, 3, 1};
    vt[5] = '{12'h004, 32'h00000000, 1'b0, 0, 32'h04030201, 1'b0, 3, 1};
    vt[6] = '{12'h2FC, 32'h00000000, 1'b0, 1, 32'h5555AAAA, 1'b0, 4, 2};
    vt[7] = '{12'h300, 32'h99999999, 1'b1, 0, 32'h00000000, 1'b1, 2, 0};
    vt[8] = '{12'hF80, 32'h00000000, 1'b0, 0, 32'h00000000, 1'b1, 2, 0};
    vt[9] = '{12'h184, 32'h00000000, 1'b0, 2, 32'h33334444, 1'b0, 5, 3};

    for (int k = 0; k < N; k++) begin
      tgt_delay[k] = 0;
      vcnt[k] = 0;
      for (int r = 0; r < 32; r++) tgt_mem[k][r] = 32'hA0000000 | 32'(k << 8) | 32'(r);
    end
    tgt_mem[1][2]  = 32'hCAFEF00D;
    tgt_mem[5][31] = 32'h5555AAAA;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 32; r++) model_mem[k][r] = tgt_mem[k][r];

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_valid", 32'(cfg_valid_o), 32'd0);
    chk("rst_addr", 32'(cfg_addr_o), 32'd0);
    chk("rst_data", cfg_data_o, 32'h0);
    chk("rst_rwn", 32'(cfg_rwn_o), 32'd0);
    rst_i = 1'b0;

    // Directed table, issued back to back
    for (int i = 0; i < 10; i++) begin
      idx = int'(vt[i].addr[11:7]);
      if (idx < N) tgt_delay[idx] = vt[i].delay;
      model(vt[i].addr, vt[i].wdata, vt[i].write, vt[i].delay, m_rd, m_err, m_cyc, m_vcyc);
      run_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].wdata, vt[i].write,
              vt[i].exp_rd, vt[i].exp_err, vt[i].exp_cyc, vt[i].exp_vcyc);
    end

`ifdef UDMA_CFG_TIMEOUT_EN
    // Never-ready target times out; ready on the very last allowed cycle still wins.
    tgt_delay[2] = 1000;
    run_chk("timeout", 12'h100, 32'h0, 1'b0, 32'h0, 1'b1, TO + 2, TO);
    tgt_delay[2] = TO - 1;
    run_chk("ready_at_limit", 12'h104, 32'h0, 1'b0, 32'hA0000201, 1'b0, TO + 2, TO);
`endif

    // Reset in the middle of an ACCESS phase to target 4
    PSEL = 1'b0; PENABLE = 1'b0;
    tgt_delay[4] = 20;
    @(negedge clk_i);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h200; PWRITE = 1'b0;
    @(negedge clk_i);
    PENABLE = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("midrst_valid_before", 32'(cfg_valid_o), 32'h10);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_valid", 32'(cfg_valid_o), 32'd0);
    chk("midrst_pready", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    tgt_delay[4] = 0;
    model(12'h200, 32'h0, 1'b0, 0, m_rd, m_err, m_cyc, m_vcyc);
    run_chk("after_rst", 12'h200, 32'h0, 1'b0, m_rd, m_err, m_cyc, m_vcyc);

    // Random transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 7);
      a   = {5'(idx), 5'($urandom_range(0, 31)), 2'b00};
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      dly = $urandom_range(0, 5);
      if (TO_EN && $urandom_range(0, 3) == 0) dly = ($urandom_range(0, 1) == 1) ? 1000 : TO - 1;
      if (idx < N) tgt_delay[idx] = dly;
      model(a, wd, wr, dly, m_rd, m_err, m_cyc, m_vcyc);
      run_chk($sformatf("rnd%0d", i), a, wd, wr, m_rd, m_err, m_cyc, m_vcyc);
    end

    @(negedge clk_i);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
